// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the memory-mapped SPI NOR flash read port.
// SPI_FLASH_FAST_READ_EN selects FAST_READ (0x0B + 8 dummy clocks) instead of READ (0x03).
package spi_flash_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    SHIFT,
    DONE
  } state_t;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;

  localparam int unsigned CMD_BITS   = 8;
  localparam int unsigned ADDR_BITS  = 24;
  localparam int unsigned DATA_BITS  = 32;
  localparam int unsigned DUMMY_BITS = 8;
  localparam int unsigned BIT_CNT_W  = 7;

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0]  READ_OPCODE = CMD_FAST_READ;
  localparam int unsigned LEAD_BITS   = CMD_BITS + ADDR_BITS + DUMMY_BITS;
`else
  localparam logic [7:0]  READ_OPCODE = CMD_READ;
  localparam int unsigned LEAD_BITS   = CMD_BITS + ADDR_BITS;
`endif

  // Bits clocked before the first data bit, plus the 32 data bits.
  localparam int unsigned TOTAL_BITS = LEAD_BITS + DATA_BITS;

  // Flash returns the lowest-addressed byte first; the bus wants it in bits [7:0].
  function automatic logic [31:0] swapBytes(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI mode-0 clock prescaler: spi_clk level plus one-cycle rise/fall strobes.
// Runs only while enabled; held low with a cleared divider otherwise.
module spi_sclk_gen
  import spi_flash_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic sclk,
  output logic riseStb_c,
  output logic fallStb_c
);

  localparam int unsigned DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  logic [DIV_W-1:0] divCnt;
  logic             lastTick_c;

  // The strobes mark the clk edge on which spi_clk toggles.
  assign lastTick_c = enable && (divCnt == DIV_W'(SCLK_DIV - 1));
  assign riseStb_c  = lastTick_c && !sclk;
  assign fallStb_c  = lastTick_c && sclk;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      divCnt <= '0;
      sclk   <= 1'b0;
    end else if (lastTick_c) begin
      divCnt <= '0;
      sclk   <= ~sclk;
    end else begin
      divCnt <= divCnt + 1'b1;
    end
  end

endmodule

// File: rtl/mapped_spi_flash.sv
// Memory-mapped single-lane SPI NOR flash reader: one strobe fetches one 32-bit word.
// Build option SPI_FLASH_FAST_READ_EN switches to FAST_READ with a dummy byte.
module mapped_spi_flash
  import spi_flash_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned SCLK_DIV   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rstrb,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [31:0]           rdata,
  output logic                  rbusy,
  output logic                  spi_cs_n,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int unsigned TX_W = CMD_BITS + ADDR_BITS;

  state_t                 state;
  logic [TX_W-1:0]        txShift;
  logic [DATA_BITS-1:0]   rxShift;
  logic [BIT_CNT_W-1:0]   bitCnt;
  logic [ADDR_BITS-1:0]   flashAddr_c;
  logic                   riseStb_c;
  logic                   fallStb_c;
  logic                   lastBit_c;
  logic                   inData_c;

  // Word-aligned 24-bit flash address, zero-extended from the bus address.
  assign flashAddr_c = ADDR_BITS'(addr) & ~ADDR_BITS'(3);
  assign lastBit_c   = (bitCnt == BIT_CNT_W'(TOTAL_BITS - 1));
  assign inData_c    = (bitCnt >= BIT_CNT_W'(LEAD_BITS));

  spi_sclk_gen #(
    .SCLK_DIV (SCLK_DIV)
  ) sclkGen (
    .clk       (clk),
    .reset     (reset),
    .enable    (state == SHIFT),
    .sclk      (spi_clk),
    .riseStb_c (riseStb_c),
    .fallStb_c (fallStb_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rbusy    <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_mosi <= 1'b0;
      rdata    <= '0;
      txShift  <= '0;
      rxShift  <= '0;
      bitCnt   <= '0;
    end else begin
      case (state)
        // DONE accepts a new strobe exactly like IDLE.
        IDLE, DONE: begin
          spi_cs_n <= 1'b1;
          spi_mosi <= 1'b0;
          rbusy    <= 1'b0;
          bitCnt   <= '0;
          state    <= IDLE;
          if (rstrb) begin
            txShift <= {READ_OPCODE, flashAddr_c};
            rbusy   <= 1'b1;
            state   <= START;
          end
        end

        // Present the first MOSI bit together with chip select.
        START: begin
          spi_cs_n <= 1'b0;
          spi_mosi <= txShift[TX_W-1];
          txShift  <= {txShift[TX_W-2:0], 1'b0};
          state    <= SHIFT;
        end

        SHIFT: begin
          if (riseStb_c && inData_c) begin
            rxShift <= {rxShift[DATA_BITS-2:0], spi_miso};
          end
          if (fallStb_c) begin
            if (lastBit_c) begin
              state    <= DONE;
              spi_cs_n <= 1'b1;
              spi_mosi <= 1'b0;
              rbusy    <= 1'b0;
              rdata    <= swapBytes(rxShift);
            end else begin
              // Zeros shifted in keep MOSI low through dummy and data bits.
              bitCnt   <= bitCnt + 1'b1;
              spi_mosi <= txShift[TX_W-1];
              txShift  <= {txShift[TX_W-2:0], 1'b0};
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mapped_spi_flash.sv
// Directed bench: two ports (SCLK_DIV 1 and 3), each talking to a small mode-0 flash model.
// Expected latency and opcode follow SPI_FLASH_FAST_READ_EN.
module tb_mapped_spi_flash;

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] EXP_CMD    = 8'h0B;
  localparam int         DATA_START = 40;
`else
  localparam logic [7:0] EXP_CMD    = 8'h03;
  localparam int         DATA_START = 32;
`endif
  localparam int BITS = DATA_START + 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0]       rstrbV = '0;
  logic [1:0][23:0] addrV  = '0;
  logic [1:0][31:0] rdataV;
  logic [1:0]       rbusyV;
  logic [1:0]       csNV;
  logic [1:0]       sclkV;
  logic [1:0]       mosiV;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];

  int   errors = 0;
  int   checks = 0;
  int   runMin;
  int   runMax;
  logic rdChanged;
  int   busy;
  logic csAtStart;
  int   startsBefore;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : lane
    logic        miso = 1'b0;
    logic [31:0] cmdAddr = '0;
    logic        mosiDirty = 1'b0;
    int          cnt = 0;
    int          starts = 0;

    mapped_spi_flash #(
      .ADDR_WIDTH (24),
      .SCLK_DIV   ((g == 0) ? 1 : 3)
    ) dut (
      .clk      (clk),
      .reset    (reset),
      .rstrb    (rstrbV[g]),
      .addr     (addrV[g]),
      .rdata    (rdataV[g]),
      .rbusy    (rbusyV[g]),
      .spi_cs_n (csNV[g]),
      .spi_clk  (sclkV[g]),
      .spi_mosi (mosiV[g]),
      .spi_miso (miso)
    );

    always @(negedge csNV[g]) starts <= starts + 1;

    // Flash samples MOSI on rising SCK; chip-select high restarts the command.
    always @(posedge sclkV[g] or posedge csNV[g]) begin
      if (csNV[g]) begin
        cnt <= 0;
      end else begin
        if (cnt < 32) cmdAddr <= {cmdAddr[30:0], mosiV[g]};
        else if (mosiV[g]) mosiDirty <= 1'b1;
        cnt <= cnt + 1;
      end
    end

    // Flash drives MISO on falling SCK once command, address and dummies are in.
    always @(negedge sclkV[g]) begin : drive
      int         d;
      logic [7:0] idx;
      logic [7:0] b;
      if (!csNV[g] && cnt >= DATA_START) begin
        d    = cnt - DATA_START;
        idx  = cmdAddr[7:0] + 8'(d / 8);
        b    = (g == 0) ? mem0[idx] : mem1[idx];
        miso <= b[7 - (d % 8)];
      end else begin
        miso <= 1'b0;
      end
    end
  end

  function automatic logic [31:0] cmdOf(input int g);
    return (g == 0) ? lane[0].cmdAddr : lane[1].cmdAddr;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the first rbusy=0 negedge (or after the cycle budget).
  task automatic doRead(input int g, input logic [23:0] a, input int midAt, input logic [23:0] midA,
                        output int nBusy, output logic csStart);
    int         run;
    logic       prev;
    logic [31:0] r0;
    rstrbV[g] = 1'b1;
    addrV[g]  = a;
    @(negedge clk);
    rstrbV[g] = 1'b0;
    csStart   = csNV[g];
    r0        = rdataV[g];
    nBusy     = 0;
    run       = 0;
    prev      = 1'b0;
    runMin    = 9999;
    runMax    = 0;
    rdChanged = 1'b0;
    while (rbusyV[g] === 1'b1 && nBusy < 2000) begin
      nBusy++;
      if (rdataV[g] !== r0) rdChanged = 1'b1;
      if (!csNV[g]) begin
        if (sclkV[g] == prev) begin
          run++;
        end else begin
          if (run < runMin) runMin = run;
          if (run > runMax) runMax = run;
          prev = sclkV[g];
          run  = 1;
        end
      end
      if (nBusy == midAt) begin
        rstrbV[g] = 1'b1;
        addrV[g]  = midA;
      end else begin
        rstrbV[g] = 1'b0;
      end
      @(negedge clk);
    end
    rstrbV[g] = 1'b0;
  endtask

  initial begin
    foreach (mem0[i]) mem0[i] = 8'h00;
    foreach (mem1[i]) mem1[i] = 8'h00;
    mem0[8'h10] = 8'h11; mem0[8'h11] = 8'h22; mem0[8'h12] = 8'h33; mem0[8'h13] = 8'h44;
    mem0[8'h20] = 8'hAA; mem0[8'h21] = 8'hBB; mem0[8'h22] = 8'hCC; mem0[8'h23] = 8'hDD;
    mem1[8'hFC] = 8'hDE; mem1[8'hFD] = 8'hAD; mem1[8'hFE] = 8'hBE; mem1[8'hFF] = 8'hEF;

    repeat (3) @(negedge clk);
    chk("reset_rbusy", 32'(rbusyV[0]), 32'd0);
    chk("reset_cs_n", 32'(csNV[0]), 32'd1);
    chk("reset_sclk", 32'(sclkV[0]), 32'd0);
    chk("reset_mosi", 32'(mosiV[0]), 32'd0);
    chk("reset_rdata", rdataV[0], 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Basic read at 0x000010.
    doRead(0, 24'h000010, -1, 24'h0, busy, csAtStart);
    chk("rd10_busy", 32'(busy), 32'(1 + BITS * 2));
    chk("rd10_rdata", rdataV[0], 32'h44332211);
    chk("rd10_cmd", cmdOf(0), {EXP_CMD, 24'h000010});
    chk("rd10_cs_start", 32'(csAtStart), 32'd1);
    chk("rd10_cs_done", 32'(csNV[0]), 32'd1);
    chk("rd10_sclk_min", 32'(runMin), 32'd1);
    chk("rd10_sclk_max", 32'(runMax), 32'd1);
    @(negedge clk);

    // Unaligned address is masked to the word.
    doRead(0, 24'h000013, -1, 24'h0, busy, csAtStart);
    chk("rd13_cmd", cmdOf(0), {EXP_CMD, 24'h000010});
    chk("rd13_rdata", rdataV[0], 32'h44332211);
    @(negedge clk);

    // SCLK_DIV=3 at the top of the address space.
    doRead(1, 24'hFFFFFC, -1, 24'h0, busy, csAtStart);
    chk("div3_busy", 32'(busy), 32'(1 + BITS * 6));
    chk("div3_rdata", rdataV[1], 32'hEFBEADDE);
    chk("div3_cmd", cmdOf(1), {EXP_CMD, 24'hFFFFFC});
    chk("div3_sclk_min", 32'(runMin), 32'd3);
    chk("div3_sclk_max", 32'(runMax), 32'd3);
    @(negedge clk);

    // Strobe during busy is ignored.
    startsBefore = lane[0].starts;
    doRead(0, 24'h000010, 40, 24'h000020, busy, csAtStart);
    chk("ign_busy", 32'(busy), 32'(1 + BITS * 2));
    chk("ign_rdata", rdataV[0], 32'h44332211);
    repeat (5) @(negedge clk);
    chk("ign_idle", 32'(rbusyV[0]), 32'd0);
    chk("ign_starts", 32'(lane[0].starts - startsBefore), 32'd1);

    // Back-to-back: second strobe lands in the DONE cycle.
    doRead(0, 24'h000020, -1, 24'h0, busy, csAtStart);
    chk("b2b_first", rdataV[0], 32'hDDCCBBAA);
    chk("b2b_done_cs", 32'(csNV[0]), 32'd1);
    doRead(0, 24'h000010, -1, 24'h0, busy, csAtStart);
    chk("b2b_start_cs", 32'(csAtStart), 32'd1);
    chk("b2b_hold", 32'(rdChanged), 32'd0);
    chk("b2b_busy", 32'(busy), 32'(1 + BITS * 2));
    chk("b2b_second", rdataV[0], 32'h44332211);
    @(negedge clk);

    // Reset at cycle 70 of a read aborts it.
    rstrbV[0] = 1'b1;
    addrV[0]  = 24'h000020;
    @(negedge clk);
    rstrbV[0] = 1'b0;
    repeat (69) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst70_cs_n", 32'(csNV[0]), 32'd1);
    chk("rst70_rbusy", 32'(rbusyV[0]), 32'd0);
    chk("rst70_rdata", rdataV[0], 32'h0);
    chk("rst70_sclk", 32'(sclkV[0]), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    doRead(0, 24'h000010, -1, 24'h0, busy, csAtStart);
    chk("post_rst_rdata", rdataV[0], 32'h44332211);
    chk("post_rst_busy", 32'(busy), 32'(1 + BITS * 2));

    chk("mosi_quiet0", 32'(lane[0].mosiDirty), 32'd0);
    chk("mosi_quiet1", 32'(lane[1].mosiDirty), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
